// File: rtl/dct_pkg.sv
// dct_pkg: shared constants, types and bus helpers for the 8x8 DCT block
// controller.
//   BLK_DIM/BLK_SZ/PIX_W : block geometry and pixel width
//   state_t              : input-side sequencer state
//   blk_t                : 64 x 8-bit packed block; element i = r*8+c sits at
//                          bits i*8 +: 8, which is the same layout as the
//                          512-bit DCT buses
package dct_pkg;

  localparam int BLK_DIM = 8;
  localparam int BLK_SZ  = BLK_DIM * BLK_DIM;
  localparam int PIX_W   = 8;
  localparam int IDX_W   = 6;
  localparam int BUS_W   = BLK_SZ * PIX_W;

  typedef enum logic {
    LOAD = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef logic [BLK_SZ-1:0][PIX_W-1:0] blk_t;

  function automatic blk_t unpack_blk(input logic [BUS_W-1:0] bus);
    blk_t blk;
    blk = bus;
    return blk;
  endfunction

  function automatic logic [BUS_W-1:0] pack_blk(input blk_t blk);
    logic [BUS_W-1:0] bus;
    bus = blk;
    return bus;
  endfunction

endpackage

// File: rtl/dct_out_buf.sv
// dct_out_buf: coefficient output buffer. It holds one captured DCT block,
// streams it in raster order over a valid/ready interface and counts fully
// drained blocks.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   capture, cap_blk    load cap_blk into the buffer (only asserted when free)
//   free                buffer can take a capture this cycle (empty, or the
//                       final beat is handshaking now)
//   obuf_full           buffer holds an undrained block
//   out_valid/ready     output handshake
//   out_data, out_idx   current coefficient and its raster index
//   out_last            valid beat with index 63
//   blk_cnt             drained-block count, wraps
module dct_out_buf
  import dct_pkg::*;
#(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture,
  input  blk_t                 cap_blk,
  output logic                 free,
  output logic                 obuf_full,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIX_W-1:0]     out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic [BLK_CNT_W-1:0] blk_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SZ - 1);

  blk_t                 obuf;
  logic                 full_q;
  logic [IDX_W-1:0]     idx_q;
  logic [BLK_CNT_W-1:0] cnt_q;
  logic                 beat;
  logic                 last_beat;

  assign beat      = full_q & out_ready;
  assign last_beat = beat & (idx_q == LAST_IDX);
  assign free      = ~full_q | last_beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      obuf   <= '0;
      full_q <= 1'b0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (beat) begin
        if (last_beat) begin
          idx_q  <= '0;
          cnt_q  <= cnt_q + 1'b1;
          full_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
      // A capture on the final beat overrides the clear so the next block
      // follows without a bubble.
      if (capture) begin
        obuf   <= cap_blk;
        full_q <= 1'b1;
        idx_q  <= '0;
      end
    end
  end

  assign obuf_full = full_q;
  assign out_valid = full_q;
  assign out_data  = obuf[idx_q];
  assign out_idx   = idx_q;
  assign out_last  = full_q & (idx_q == LAST_IDX);
  assign blk_cnt   = cnt_q;

endmodule

// File: rtl/dct_block_ctrl.sv
// dct_block_ctrl: sequencer for the 8x8 two-stage DCT array. Collects a
// raster pixel stream into a block register that drives the DCT input, waits
// the DCT pipeline latency, captures the coefficient block and streams it out.
// Loading of the next block overlaps streaming of the current one.
// Build option: define DCT_LEVEL_SHIFT_EN to store each pixel as in_data-128
// (JPEG level shift, bit 7 inverted); otherwise pixels are stored unchanged.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   raster pixel input
//   dct_x                       block register to the DCT (registered)
//   dct_y                       DCT result, same packing
//   out_valid/out_ready         coefficient output handshake
//   out_data/out_idx/out_last   coefficient, raster index, final-beat flag
//   busy                        anything in flight
//   blk_cnt                     drained-block count, wraps
//
// state | meaning
// LOAD  | accepting pixels into xbuf, in_idx is the next write slot
// WAIT  | xbuf frozen; counting DCT latency, then capture when obuf is free
module dct_block_ctrl
  import dct_pkg::*;
#(
  parameter int DCT_LAT   = 2,
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_W-1:0]     in_data,
  output logic [BUS_W-1:0]     dct_x,
  input  logic [BUS_W-1:0]     dct_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIX_W-1:0]     out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_cnt
);

  localparam int               WC_W     = (DCT_LAT < 1) ? 1 : $clog2(DCT_LAT + 1);
  localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(DCT_LAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SZ - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] in_idx, in_idx_nxt;
  logic [WC_W-1:0]  wait_cnt, wait_cnt_nxt;
  blk_t             xbuf;
  logic [PIX_W-1:0] pix_st;
  logic             wr_en;
  logic             capture;
  logic             ob_free;
  logic             ob_full;

`ifdef DCT_LEVEL_SHIFT_EN
  assign pix_st = {~in_data[PIX_W-1], in_data[PIX_W-2:0]};
`else
  assign pix_st = in_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LOAD;
      in_idx   <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      in_idx   <= in_idx_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    in_idx_nxt   = in_idx;
    wait_cnt_nxt = wait_cnt;
    in_ready     = 1'b0;
    wr_en        = 1'b0;
    capture      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (in_idx == LAST_IDX) begin
            state_nxt    = WAIT;
            in_idx_nxt   = '0;
            wait_cnt_nxt = '0;
          end else begin
            in_idx_nxt = in_idx + 1'b1;
          end
        end
      end
      WAIT: begin
        // xbuf is held for the whole stall, so dct_y stays valid until the
        // output buffer frees up.
        if (wait_cnt != WC_MAX) begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end else if (ob_free) begin
          capture   = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xbuf <= '0;
    end else if (wr_en) begin
      xbuf[in_idx] <= pix_st;
    end
  end

  assign dct_x = pack_blk(xbuf);
  assign busy  = (state != LOAD) | (in_idx != '0) | ob_full;

  dct_out_buf #(
    .BLK_CNT_W(BLK_CNT_W)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .cap_blk  (unpack_blk(dct_y)),
    .free     (ob_free),
    .obuf_full(ob_full),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .blk_cnt  (blk_cnt)
  );

endmodule

// File: tb/tb_dct_block_ctrl.sv
`timescale 1ns/1ps
module tb_dct_block_ctrl;

  localparam int DCT_LAT   = 2;
  localparam int BLK_CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [7:0]           in_data = 8'h00;
  logic [511:0]         dct_x;
  logic [511:0]         dct_y;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [7:0]           out_data;
  logic [5:0]           out_idx;
  logic                 out_last;
  logic                 busy;
  logic [BLK_CNT_W-1:0] blk_cnt;

  always #5 clk = ~clk;

  dct_block_ctrl #(.DCT_LAT(DCT_LAT), .BLK_CNT_W(BLK_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dct_x(dct_x), .dct_y(dct_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .blk_cnt(blk_cnt)
  );

  // stub DCT: DCT_LAT register stages passing x straight to y
  logic [511:0] y_pipe [DCT_LAT];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DCT_LAT; i++) y_pipe[i] <= '0;
    end else begin
      y_pipe[0] <= dct_x;
      for (int i = 1; i < DCT_LAT; i++) y_pipe[i] <= y_pipe[i-1];
    end
  end
  assign dct_y = y_pipe[DCT_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         tot = 0;
  int         bad = 0;
  int         exp_blk = 0;
  logic       sent_ok;
  logic [7:0] got_data[$];
  logic [5:0] got_idx[$];
  logic       got_last[$];
  int         got_cyc[$];
  logic [7:0] exp_data[$];

  function automatic logic [7:0] ls(input logic [7:0] v);
`ifdef DCT_LEVEL_SHIFT_EN
    return v ^ 8'h80;
`else
    return v;
`endif
  endfunction

  function automatic logic [511:0] pack64(input logic [7:0] p [64]);
    logic [511:0] v;
    for (int i = 0; i < 64; i++) v[i*8 +: 8] = ls(p[i]);
    return v;
  endfunction

  // index of the first beat disagreeing with exp_data/raster idx/last, or -1
  function automatic int first_diff();
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      if (got_data[i] !== exp_data[i] || got_idx[i] !== 6'(i % 64) ||
          got_last[i] !== (i % 64 == 63))
        return i;
    end
    return -1;
  endfunction

  // tasks start and end 1ns after a rising edge
  task automatic send_block(input logic [7:0] p [64], input int n, input int gap);
    int k = 0, run = 0, c = 0;
    logic acc;
    while (k < n && c < 4000) begin
      if (gap > 0 && run == gap) begin
        in_valid = 1'b0;
        run = 0;
        @(posedge clk); #1; c++;
      end else begin
        in_valid = 1'b1;
        in_data  = p[k];
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1; c++;
        if (acc) begin k++; run++; end
      end
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    sent_ok  = (k == n);
  endtask

  task automatic drain(input int n);
    int c = 0;
    got_data.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
    while (got_data.size() < n && c < 4000) begin
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        got_data.push_back(out_data); got_idx.push_back(out_idx);
        got_last.push_back(out_last); got_cyc.push_back(cyc);
      end
      @(posedge clk); #1; c++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tot++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    tot++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    tot++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
    tot++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tot++; if (blk_cnt !== '0) begin bad++; $display("FAIL rst_blk_cnt got=%0d exp=0", blk_cnt); end
    tot++; if (dct_x !== '0) begin bad++; $display("FAIL rst_dct_x got nonzero exp=0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] p [64];
    int low = 0, fd;
    logic ov_back = 1'b0, busy_wait = 1'b0;
    for (int k = 0; k < 64; k++) p[k] = 8'(k);
    exp_data.delete();
    for (int k = 0; k < 64; k++) exp_data.push_back(ls(8'(k)));
    fork
      begin
        send_block(p, 64, 0);
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (in_ready) begin ov_back = out_valid; break; end
          if (low == 0) busy_wait = busy;
          low++;
          @(posedge clk); #1;
        end
      end
      drain(64);
    join
    exp_blk++;
    fd = first_diff();
    tot++; if (sent_ok !== 1'b1) begin bad++; $display("FAIL single_sent got=%b exp=1", sent_ok); end
    tot++; if (low != 3) begin bad++; $display("FAIL single_in_ready_low got=%0d exp=3", low); end
    tot++; if (ov_back !== 1'b1) begin bad++; $display("FAIL single_capture_timing out_valid=%b exp=1", ov_back); end
    tot++; if (busy_wait !== 1'b1) begin bad++; $display("FAIL single_busy_wait got=%b exp=1", busy_wait); end
    tot++; if (got_data.size() != 64) begin bad++; $display("FAIL single_beats got=%0d exp=64", got_data.size()); end
    tot++; if (fd != -1) begin bad++; $display("FAIL single_seq at=%0d data=%h exp=%h idx=%0d last=%b", fd, got_data[fd], exp_data[fd], got_idx[fd], got_last[fd]); end
    tot++; if (blk_cnt !== BLK_CNT_W'(exp_blk)) begin bad++; $display("FAIL single_blk_cnt got=%0d exp=%0d", blk_cnt, exp_blk); end
    tot++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", out_valid); end
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    tot++; if (dct_x !== pack64(p)) begin bad++; $display("FAIL single_dct_x got=%h exp=%h", dct_x[63:0], pack64(p) >> 0); end
  endtask

  task automatic test_level_shift();
    logic [7:0] p [64];
    logic [7:0] v;
    int fd;
    for (int b = 0; b < 2; b++) begin
      v = (b == 0) ? 8'h80 : 8'h00;
      for (int k = 0; k < 64; k++) p[k] = v;
      exp_data.delete();
      for (int k = 0; k < 64; k++) exp_data.push_back(ls(v));
      fork
        send_block(p, 64, 0);
        drain(64);
      join
      exp_blk++;
      fd = first_diff();
      tot++; if (got_data.size() != 64) begin bad++; $display("FAIL lshift_beats in=%h got=%0d exp=64", v, got_data.size()); end
      tot++; if (fd != -1) begin bad++; $display("FAIL lshift_seq in=%h at=%0d got=%h exp=%h", v, fd, got_data[fd], exp_data[fd]); end
      tot++; if (dct_x[7:0] !== ls(v)) begin bad++; $display("FAIL lshift_dct_x in=%h got=%h exp=%h", v, dct_x[7:0], ls(v)); end
      tot++; if (blk_cnt !== BLK_CNT_W'(exp_blk)) begin bad++; $display("FAIL lshift_blk_cnt got=%0d exp=%0d", blk_cnt, exp_blk); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [64];
    logic [7:0] pb [64];
    int fd;
    for (int k = 0; k < 64; k++) begin pa[k] = 8'(k); pb[k] = 8'(64 + k); end
    exp_data.delete();
    for (int k = 0; k < 128; k++) exp_data.push_back(ls(8'(k)));
    out_ready = 1'b0;
    send_block(pa, 64, 0);
    send_block(pb, 64, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    tot++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_in_ready got=%b exp=0", in_ready); end
    tot++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_stall_busy got=%b exp=1", busy); end
    tot++; if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_data !== ls(8'h00)) begin
      bad++; $display("FAIL b2b_stall_out valid=%b idx=%0d data=%h exp 1/0/%h", out_valid, out_idx, out_data, ls(8'h00)); end
    tot++; if (dct_x !== pack64(pb)) begin bad++; $display("FAIL b2b_stall_dct_x got=%h exp=%h", dct_x[63:0], pack64(pb) >> 0); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    tot++; if (dct_x !== pack64(pb) || in_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_stall_hold in_ready=%b dct_x_lo=%h exp=%h", in_ready, dct_x[63:0], pack64(pb) >> 0); end
    @(posedge clk); #1;
    drain(128);
    exp_blk += 2;
    fd = first_diff();
    tot++; if (got_data.size() != 128) begin bad++; $display("FAIL b2b_beats got=%0d exp=128", got_data.size()); end
    tot++; if (fd != -1) begin bad++; $display("FAIL b2b_seq at=%0d got=%h exp=%h idx=%0d", fd, got_data[fd], exp_data[fd], got_idx[fd]); end
    if (got_cyc.size() == 128) begin
      tot++; if (got_cyc[64] - got_cyc[63] != 1) begin bad++; $display("FAIL b2b_gap got=%0d exp=1", got_cyc[64] - got_cyc[63]); end
    end
    tot++; if (blk_cnt !== BLK_CNT_W'(exp_blk)) begin bad++; $display("FAIL b2b_blk_cnt got=%0d exp=%0d", blk_cnt, exp_blk); end
    tot++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_random_gaps();
    logic [7:0] p [64];
    int fd;
    for (int k = 0; k < 64; k++) p[k] = 8'((k * 7 + 3) % 256);
    exp_data.delete();
    for (int k = 0; k < 64; k++) exp_data.push_back(ls(p[k]));
    got_data.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
    fork
      send_block(p, 64, 3);
      begin
        int c = 0;
        logic pv = 1'b0, pr = 1'b0;
        logic [7:0] pd = 8'h00;
        logic [5:0] pi = 6'd0;
        while (got_data.size() < 64 && c < 4000) begin
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (pv && !pr) begin
            tot++;
            if (out_valid !== 1'b1 || out_data !== pd || out_idx !== pi) begin
              bad++; $display("FAIL rand_hold valid=%b data=%h idx=%0d exp 1/%h/%0d", out_valid, out_data, out_idx, pd, pi);
            end
          end
          pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx;
          if (out_valid && out_ready) begin
            got_data.push_back(out_data); got_idx.push_back(out_idx);
            got_last.push_back(out_last); got_cyc.push_back(cyc);
          end
          @(posedge clk); #1; c++;
        end
        out_ready = 1'b0;
      end
    join
    exp_blk++;
    fd = first_diff();
    tot++; if (sent_ok !== 1'b1) begin bad++; $display("FAIL rand_sent got=%b exp=1", sent_ok); end
    tot++; if (got_data.size() != 64) begin bad++; $display("FAIL rand_beats got=%0d exp=64", got_data.size()); end
    tot++; if (fd != -1) begin bad++; $display("FAIL rand_seq at=%0d got=%h exp=%h idx=%0d", fd, got_data[fd], exp_data[fd], got_idx[fd]); end
    tot++; if (dct_x !== pack64(p)) begin bad++; $display("FAIL gap_dct_x got=%h exp=%h", dct_x[63:0], pack64(p) >> 0); end
    tot++; if (blk_cnt !== BLK_CNT_W'(exp_blk)) begin bad++; $display("FAIL rand_blk_cnt got=%0d exp=%0d", blk_cnt, exp_blk); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] p [64];
    logic [7:0] q [64];
    int fd;
    for (int k = 0; k < 64; k++) begin p[k] = 8'(k + 100); q[k] = 8'(255 - k); end
    send_block(p, 30, 0);
    rst = 1'b0;
    #1;
    tot++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rstload_ctl in_ready=%b busy=%b out_valid=%b exp 1/0/0", in_ready, busy, out_valid); end
    tot++; if (dct_x !== '0) begin bad++; $display("FAIL rstload_dct_x got=%h exp=0", dct_x[63:0]); end
    tot++; if (blk_cnt !== '0) begin bad++; $display("FAIL rstload_blk_cnt got=%0d exp=0", blk_cnt); end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_blk = 0;
    exp_data.delete();
    for (int k = 0; k < 64; k++) exp_data.push_back(ls(p[k]));
    fork
      send_block(p, 64, 0);
      drain(20);
    join
    tot++; if (out_valid !== 1'b1 || out_idx !== 6'd20 || out_data !== ls(p[20])) begin
      bad++; $display("FAIL rstout_pre valid=%b idx=%0d data=%h exp 1/20/%h", out_valid, out_idx, out_data, ls(p[20])); end
    rst = 1'b0;
    #1;
    tot++; if (out_valid !== 1'b0 || out_idx !== 6'd0 || out_data !== 8'h00 || out_last !== 1'b0) begin
      bad++; $display("FAIL rstout_out valid=%b idx=%0d data=%h last=%b exp 0/0/00/0", out_valid, out_idx, out_data, out_last); end
    tot++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstout_ctl busy=%b in_ready=%b exp 0/1", busy, in_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_data.delete();
    for (int k = 0; k < 64; k++) exp_data.push_back(ls(q[k]));
    fork
      send_block(q, 64, 0);
      drain(64);
    join
    exp_blk++;
    fd = first_diff();
    tot++; if (got_data.size() != 64) begin bad++; $display("FAIL rstpost_beats got=%0d exp=64", got_data.size()); end
    tot++; if (fd != -1) begin bad++; $display("FAIL rstpost_seq at=%0d got=%h exp=%h idx=%0d", fd, got_data[fd], exp_data[fd], got_idx[fd]); end
    tot++; if (blk_cnt !== BLK_CNT_W'(exp_blk)) begin bad++; $display("FAIL rstpost_blk_cnt got=%0d exp=%0d", blk_cnt, exp_blk); end
    tot++; if (dct_x !== pack64(q)) begin bad++; $display("FAIL rstpost_dct_x got=%h exp=%h", dct_x[63:0], pack64(q) >> 0); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_level_shift();
    test_back_to_back();
    test_random_gaps();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
